gin_xbus: RTL



---
 rtl/gin_pkg.sv | 20 ++
 rtl/gin_xbus_if.sv | 35 +++
 rtl/gin_xbus_imcc.sv | 72 +++++++
 rtl/gin_xbus.sv | 68 ++++++
 4 files changed

// File: rtl/gin_pkg.sv
// rtl/gin_pkg.sv - shared width defaults and scan-length helper for the input X-bus
//
// Purpose : default parameter values for gin_xbus and its column cells, plus the
//           number of scan edges needed to load every column ID.
// Contents: DATA_WIDTH_DEF, COL_TAG_WIDTH_DEF, NUM_OF_COLS_DEF, scan_len(), SCAN_LEN_DEF
package gin_pkg;

    localparam int DATA_WIDTH_DEF    = 64;
    localparam int COL_TAG_WIDTH_DEF = 4;
    localparam int NUM_OF_COLS_DEF   = 14;

    // One scan edge moves every ID bit by one position, so a full load walks
    // the complete concatenation of all column IDs.
    function automatic int scan_len(input int num_cols, input int tag_width);
        return num_cols * tag_width;
    endfunction

    localparam int SCAN_LEN_DEF = NUM_OF_COLS_DEF * COL_TAG_WIDTH_DEF;

endpackage

// File: rtl/gin_xbus_if.sv
// rtl/gin_xbus_if.sv - upstream and per-column handshake bundle of the input X-bus
//
// Purpose : groups the upstream word handshake and the per-column delivery
//           handshakes of gin_xbus.
// Signals : data_in/col_tag/enable_in/ready_out - upstream word, tag, valid, ready
//           data_out/enable_out/ready_in         - per-column payload, valid, ready
// Modports: slave  - the bus itself (gin_xbus)
//           master - the surrounding logic (upstream buffer plus PE columns)
interface gin_xbus_if
    import gin_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int COL_TAG_WIDTH = COL_TAG_WIDTH_DEF,
    parameter int NUM_OF_COLS   = NUM_OF_COLS_DEF
) ();

    logic [DATA_WIDTH-1:0]    data_in;
    logic [COL_TAG_WIDTH-1:0] col_tag;
    logic                     enable_in;
    logic                     ready_out;
    logic [DATA_WIDTH-1:0]    data_out [NUM_OF_COLS];
    logic [0:NUM_OF_COLS-1]   enable_out;
    logic [0:NUM_OF_COLS-1]   ready_in;

    modport slave (
        input  data_in, col_tag, enable_in, ready_in,
        output ready_out, data_out, enable_out
    );

    modport master (
        output data_in, col_tag, enable_in, ready_in,
        input  ready_out, data_out, enable_out
    );

endinterface

// File: rtl/gin_xbus_imcc.sv
// rtl/gin_xbus_imcc.sv - one column cell: ID scan register, tag compare, one-entry buffer
//
// Purpose : holds the scan-loaded column ID, flags a tag match, and buffers one
//           word for its column with an independent valid/ready handshake.
// Ports   : i_clk, i_reset            - clock, synchronous active-high reset
//           i_se_id, i_si_id, o_so_id - ID scan enable / in / out (shift right)
//           i_col_tag, i_data_in      - word currently offered on the bus
//           i_accept                  - the bus takes the offered word this edge
//           i_ready_in                - column ready
//           o_match, o_can_accept     - feed the bus-level ready reduction
//           o_enable_out, o_data_out  - column valid and payload
module imcc
    import gin_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int COL_TAG_WIDTH = COL_TAG_WIDTH_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_se_id,
    input  logic                     i_si_id,
    output logic                     o_so_id,
    input  logic [COL_TAG_WIDTH-1:0] i_col_tag,
    input  logic [DATA_WIDTH-1:0]    i_data_in,
    input  logic                     i_accept,
    input  logic                     i_ready_in,
    output logic                     o_match,
    output logic                     o_can_accept,
    output logic                     o_enable_out,
    output logic [DATA_WIDTH-1:0]    o_data_out
);

    logic [COL_TAG_WIDTH-1:0] r_id;
    logic                     r_valid;
    logic [DATA_WIDTH-1:0]    r_buf;

    logic                     w_drain;
    logic                     w_load;

    assign o_so_id      = r_id[0];
    assign o_match      = (r_id == i_col_tag);
    assign o_enable_out = r_valid && !i_se_id;
    assign o_data_out   = r_buf;

    // A held word may be replaced only if it leaves on this same edge; scan
    // mode freezes delivery, so a full slot cannot drain while scanning.
    assign o_can_accept = !r_valid || (i_ready_in && !i_se_id);

    assign w_drain = o_enable_out && i_ready_in;
    assign w_load  = i_accept && o_match;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_id    <= '0;
            r_valid <= 1'b0;
            r_buf   <= '0;
        end else begin
            // Written as shift-and-insert so a 1-bit ID width also works.
            if (i_se_id) begin
                r_id <= (r_id >> 1) | (COL_TAG_WIDTH'(i_si_id) << (COL_TAG_WIDTH - 1));
            end
            // Reload wins over drain: valid stays set and the new word replaces the old.
            if (w_load) begin
                r_valid <= 1'b1;
                r_buf   <= i_data_in;
            end else if (w_drain) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gin_xbus.sv
// rtl/gin_xbus.sv - input-direction X-bus: multicasts tagged words to matching columns
//
// Purpose : accepts one tagged word per upstream handshake and loads it into
//           every column whose scan-loaded ID equals the tag; words with no
//           matching column are consumed and dropped.
// Ports   : link_clk, reset           - clock, synchronous active-high reset
//           bus (gin_xbus_if.slave)   - upstream and per-column handshakes
//           se_id, si_id, so_id       - column ID scan chain (column 0 first)
module gin_xbus
    import gin_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int COL_TAG_WIDTH = COL_TAG_WIDTH_DEF,
    parameter int NUM_OF_COLS   = NUM_OF_COLS_DEF
) (
    input  logic       link_clk,
    input  logic       reset,
    gin_xbus_if.slave  bus,
    input  logic       se_id,
    input  logic       si_id,
    output logic       so_id
);

    logic                   w_match      [NUM_OF_COLS];
    logic                   w_can_accept [NUM_OF_COLS];
    logic [NUM_OF_COLS:0]   w_scan;
    logic                   w_ready;
    logic                   w_accept;

    assign w_scan[0] = si_id;
    assign so_id     = w_scan[NUM_OF_COLS];

    // Only columns the current tag targets can stall the bus; enable_in is
    // deliberately kept out of this path so ready never depends on valid.
    always_comb begin
        w_ready = !se_id;
        for (int i = 0; i < NUM_OF_COLS; i++) begin
            if (w_match[i] && !w_can_accept[i]) begin
                w_ready = 1'b0;
            end
        end
    end

    assign bus.ready_out = w_ready;
    assign w_accept      = bus.enable_in && w_ready;

    for (genvar g = 0; g < NUM_OF_COLS; g++) begin : g_col
        imcc #(
            .DATA_WIDTH    (DATA_WIDTH),
            .COL_TAG_WIDTH (COL_TAG_WIDTH)
        ) u_imcc (
            .i_clk        (link_clk),
            .i_reset      (reset),
            .i_se_id      (se_id),
            .i_si_id      (w_scan[g]),
            .o_so_id      (w_scan[g+1]),
            .i_col_tag    (bus.col_tag),
            .i_data_in    (bus.data_in),
            .i_accept     (w_accept),
            .i_ready_in   (bus.ready_in[g]),
            .o_match      (w_match[g]),
            .o_can_accept (w_can_accept[g]),
            .o_enable_out (bus.enable_out[g]),
            .o_data_out   (bus.data_out[g])
        );
    end

endmodule
